hilo_mdu: RTL and testbench
===========================

# hilo_mdu

Multi-cycle multiply/divide unit that produces the 64-bit {HI,LO} value and the write-enable pulse consumed by the HI/LO register. It sits beside the ALU in the execute stage. It accepts one MULT/DIV/MADD/MSUB-family operation at a time, holds `busy` so the pipeline stalls, and emits exactly one write per completed, non-flushed operation.

## Interface
- `MUL_LAT`, default 2: cycles from the accepting `start` edge to the `hilo_wen` cycle for the multiply family; legal range 1–4.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: operation request; sampled only in IDLE.
- `op` in 3: operation, `mdu_op_e`: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
- `src_a` in 32: rs value (multiplicand / dividend).
- `src_b` in 32: rt value (multiplier / divisor).
- `hilo_cur` in 64: current {HI,LO}; captured with `start` for MADD/MSUB.
- `flush` in 1: exception/cancel; aborts the in-flight operation.
- `busy` out 1: registered, high whenever the state is not IDLE.
- `hilo_wen` out 1: one-cycle write pulse to the HI/LO register.
- `hilo_wdata` out 64: {HI,LO} result; valid when `hilo_wen` is high.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: `start` & ~`flush` captures `op`, `src_a`, `src_b` and `hilo_cur`.
  - Multiply ops go to MUL.
  - DIV/DIVU goes to DIV with the iteration counter at 0.
- `start` outside IDLE is ignored. The pipeline holds the instruction while `busy` is high.
- MUL: signed or unsigned 32x32→64 product, registered over MUL_LAT−1 cycles, then DONE.
- MADD/MADDU: result = hilo_acc + product. MSUB/MSUBU: result = hilo_acc − product. Both use modulo 2^64 wrap; no overflow flag.
- DIV: a restoring radix-2 divider works on |a| and |b| for signed ops, one quotient bit per cycle, 32 iterations, then DONE.
  - Fixup in DONE: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Result = {HI=remainder, LO=quotient}.
  - INT_MIN / −1 gives LO=0x80000000, HI=0.
- Divide by zero (either signedness): HI=src_a, LO=0xFFFFFFFF. Still takes the full 34-cycle path.
- DONE: `hilo_wen` = ~`flush` for one cycle, `hilo_wdata` = result, then IDLE.
- `flush` in any non-IDLE state: next state IDLE, no `hilo_wen` (this includes the DONE cycle).
- Reset: state IDLE, `busy`=0, `hilo_wen`=0, `hilo_wdata`=0, counter and all operand/accumulator registers 0. Asserting `rst` mid-operation discards the operation with no write.

## Timing
- Cycle 0 = the cycle with an accepted `start`.
- Multiply family: `busy` high in cycles 1..MUL_LAT, `hilo_wen` in cycle MUL_LAT, `busy` low in cycle MUL_LAT+1.
- Divide: `busy` high in cycles 1..34. Iterations occupy cycles 1..32, fixup happens in cycles 33–34, `hilo_wen` is asserted in cycle 34.
- Back-to-back operations: a new `start` is accepted in the first cycle `busy` is low.
- Data written with `hilo_wen` in cycle N is visible on `hilo_cur` in cycle N+1, so a following MADD sees the updated value.

## Structure
- `mdu_pkg` holds:
  - `mdu_op_e` (3-bit encoding).
  - `mdu_state_e`.
  - `DIV_ITERS`=32.
  - The divide-by-zero LO constant 0xFFFFFFFF.
- Sub-module `mdu_div_radix2` contains the iterative divider: signed pre/post fixup, counter and `done` strobe. The top level keeps the FSM, the multiplier pipeline and the accumulate logic.

## Test plan
- MULT, a=0xFFFFFFFD (−3), b=5 → `hilo_wen` in cycle 2 (MUL_LAT=2), `hilo_wdata`=0xFFFFFFFF_FFFFFFF1; MULTU with the same operands → 0x00000004_FFFFFFF1.
- DIVU 100/7 → `hilo_wen` in cycle 34, HI=2, LO=14. DIV −7/2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- DIV a=0x12345678, b=0 → HI=0x12345678, LO=0xFFFFFFFF in cycle 34. DIV 0x80000000/0xFFFFFFFF → HI=0, LO=0x80000000.
- MADDU with `hilo_cur`=0x00000000_FFFFFFFF, 1×1 → 0x00000001_00000000. MSUBU with `hilo_cur`=0, 1×1 → 0xFFFFFFFF_FFFFFFFF.
- `flush` in cycle 10 of a DIV → no `hilo_wen`, `busy`=0 in cycle 11. MULTU 2×3 started in cycle 11 → 0x00000000_00000006. A second `start` asserted while busy is ignored (exactly one write).
- `rst` pulsed in cycle 5 of a DIV (asynchronous, mid-cycle) → `busy`, `hilo_wen` and `hilo_wdata` are 0 immediately, and no write occurs afterwards.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg: shared types, constants and the multiply/accumulate helper.
// Rev 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    localparam int          DIV_ITERS   = 32;
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Sign-extending to 64 bits lets one unsigned multiply serve both signednesses.
    function automatic logic [63:0] mul_result(input mdu_op_e op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
        logic        sgn;
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] prod;
        sgn  = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
        xa   = {{32{sgn & a[31]}}, a};
        xb   = {{32{sgn & b[31]}}, b};
        prod = xa * xb;
        case (op)
            OP_MADD, OP_MADDU: return acc + prod;
            OP_MSUB, OP_MSUBU: return acc - prod;
            default:           return prod;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_div_radix2.sv
// ============================================================================
// mdu_div_radix2: 32-iteration restoring divider with signed pre/post fixup.
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_div_radix2
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CW = $clog2(DIV_ITERS + 1);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rem;
    logic [31:0]   r_quo;
    logic [31:0]   r_dvs;
    logic [31:0]   r_dvd_orig;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_zero;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    assign w_abs_a = (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
    assign w_abs_b = (is_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active   <= 1'b0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_dvd_orig <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_zero     <= 1'b0;
        end else if (start) begin
            r_active   <= 1'b1;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= w_abs_a;
            r_dvs      <= w_abs_b;
            r_dvd_orig <= dividend;
            r_neg_q    <= is_signed && (dividend[31] ^ divisor[31]);
            r_neg_r    <= is_signed && dividend[31];
            r_zero     <= (divisor == 32'd0);
        end else if (abort) begin
            r_active <= 1'b0;
        end else if (r_active) begin
            if (r_cnt != CW'(DIV_ITERS)) begin
                // Dividend bits shift out of the quotient register as quotient bits shift in.
                if (!w_diff[32]) begin
                    r_rem <= w_diff[31:0];
                    r_quo <= {r_quo[30:0], 1'b1};
                end else begin
                    r_rem <= w_shift[31:0];
                    r_quo <= {r_quo[30:0], 1'b0};
                end
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    assign done      = r_active && (r_cnt == CW'(DIV_ITERS));
    assign quotient  = r_zero ? DIV_ZERO_LO : (r_neg_q ? (32'd0 - r_quo) : r_quo);
    assign remainder = r_zero ? r_dvd_orig  : (r_neg_r ? (32'd0 - r_rem) : r_rem);

endmodule

`default_nettype wire

// File: rtl/hilo_mdu.sv
// ============================================================================
// hilo_mdu: multi-cycle multiply/divide/accumulate unit feeding the HI/LO register.
// Rev 1.0
// ============================================================================
`default_nettype none

module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  mdu_op_e     op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [63:0] hilo_cur,
    input  logic        flush,
    output logic        busy,
    output logic        hilo_wen,
    output logic [63:0] hilo_wdata
);

    localparam logic [1:0] c_mul_last = (MUL_LAT > 1) ? 2'(MUL_LAT - 2) : 2'd0;

    mdu_state_e  r_state;
    mdu_op_e     r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic [1:0]  r_cnt;

    logic        w_accept;
    logic        w_div_start;
    logic        w_div_done;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_accept    = (r_state == ST_IDLE) && start && !flush;
    assign w_div_start = w_accept && op_is_div(op);

    mdu_div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .abort     (flush),
        .is_signed (op == OP_DIV),
        .dividend  (src_a),
        .divisor   (src_b),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            busy       <= 1'b0;
            hilo_wdata <= '0;
            r_op       <= OP_MULT;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_a   <= src_a;
                        r_b   <= src_b;
                        r_acc <= hilo_cur;
                        r_cnt <= '0;
                        busy  <= 1'b1;
                        if (op_is_div(op)) begin
                            r_state <= ST_DIV;
                        end else if (MUL_LAT == 1) begin
                            // Single-cycle latency: result is formed straight from the inputs.
                            hilo_wdata <= mul_result(op, src_a, src_b, hilo_cur);
                            r_state    <= ST_DONE;
                        end else begin
                            r_state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (r_cnt == c_mul_last) begin
                        hilo_wdata <= mul_result(r_op, r_a, r_b, r_acc);
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (w_div_done) begin
                        hilo_wdata <= {w_rem, w_quo};
                        r_state    <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // A flush landing in the DONE cycle still has to suppress the write.
    assign hilo_wen = (r_state == ST_DONE) && !flush;

endmodule

`default_nettype wire

// File: tb/tb_hilo_mdu.sv
// ============================================================================
// tb_hilo_mdu: randomized and directed self-checking bench for hilo_mdu.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hilo_mdu;
    import mdu_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    mdu_op_e     op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [63:0] hilo_cur;
    logic [63:0] cur_drive;
    logic [63:0] hilo_reg;
    logic        use_reg;
    logic        busy;
    logic        hilo_wen;
    logic [63:0] hilo_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign hilo_cur = use_reg ? hilo_reg : cur_drive;

    always @(posedge clk or posedge rst) begin
        if (rst) hilo_reg <= '0;
        else if (hilo_wen) hilo_reg <= hilo_wdata;
    end

    hilo_mdu #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .hilo_cur   (hilo_cur),
        .flush      (flush),
        .busy       (busy),
        .hilo_wen   (hilo_wen),
        .hilo_wdata (hilo_wdata)
    );

    function automatic logic [63:0] ref_result(input mdu_op_e o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] ps;
        logic [63:0] pu;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        ps = sa * sb;
        pu = ua * ub;
        case (o)
            OP_MULT:  return ps;
            OP_MULTU: return pu;
            OP_MADD:  return cur + ps;
            OP_MADDU: return cur + pu;
            OP_MSUB:  return cur - ps;
            OP_MSUBU: return cur - pu;
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = longint'(ua / ub);
                r = longint'(ua % ub);
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic int ref_lat(input mdu_op_e o);
        return (o == OP_DIV || o == OP_DIVU) ? DIV_LAT : MUL_LAT;
    endfunction

    // Called mid-cycle (after a falling edge); the start is accepted at the next rising edge.
    task automatic run_op(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] cur, output int wcnt, output int wcyc,
                          output logic [63:0] wdat, output int idle_cyc);
        int cyc;
        wcnt = 0; wcyc = -1; wdat = '0; idle_cyc = -1;
        op = o; src_a = a; src_b = b; cur_drive = cur; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (hilo_wen) begin
                wcnt++;
                wcyc = cyc;
                wdat = hilo_wdata;
            end
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MULT;
        src_a = '0; src_b = '0; cur_drive = '0; use_reg = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (hilo_wen !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b want 0", hilo_wen); end
        total++; if (hilo_wdata !== 64'd0) begin bad++; $display("FAIL reset_wdata: got %h want 0", hilo_wdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        mdu_op_e     d_op  [9];
        logic [31:0] d_a   [9];
        logic [31:0] d_b   [9];
        logic [63:0] d_cur [9];
        logic [63:0] d_exp [9];
        int wcnt, wcyc, idle, lat;
        logic [63:0] wdat;
        d_op  = '{OP_MULT, OP_MULTU, OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_MADDU, OP_MSUBU, OP_DIVU};
        d_a   = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h1234_5678,
                  32'h8000_0000, 32'd1, 32'd1, 32'd5};
        d_b   = '{32'd5, 32'd5, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0};
        d_cur = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'd0};
        d_exp = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0004_FFFF_FFF1, 64'h0000_0002_0000_000E,
                  64'hFFFF_FFFF_FFFF_FFFD, 64'h1234_5678_FFFF_FFFF, 64'h0000_0000_8000_0000,
                  64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0005_FFFF_FFFF};
        for (int i = 0; i < 9; i++) begin
            lat = ref_lat(d_op[i]);
            run_op(d_op[i], d_a[i], d_b[i], d_cur[i], wcnt, wcyc, wdat, idle);
            total++; if (wcnt !== 1) begin bad++; $display("FAIL dir%0d_wcount: got %0d want 1", i, wcnt); end
            total++; if (wcyc !== lat) begin bad++; $display("FAIL dir%0d_wcycle: got %0d want %0d", i, wcyc, lat); end
            total++; if (wdat !== d_exp[i]) begin bad++; $display("FAIL dir%0d_data: got %h want %h", i, wdat, d_exp[i]); end
            total++; if (idle !== lat + 1) begin bad++; $display("FAIL dir%0d_idle: got %0d want %0d", i, idle, lat + 1); end
        end
    endtask

    task automatic test_chain();
        int wcnt, wcyc, idle;
        logic [63:0] wdat, exp1, exp2;
        use_reg = 1'b1;
        exp1 = ref_result(OP_MULT, 32'd7, 32'd6, 64'd0);
        run_op(OP_MULT, 32'd7, 32'd6, 64'd0, wcnt, wcyc, wdat, idle);
        total++; if (wdat !== exp1) begin bad++; $display("FAIL chain_mult: got %h want %h", wdat, exp1); end
        exp2 = ref_result(OP_MADD, 32'hFFFF_FFFE, 32'd3, exp1);
        run_op(OP_MADD, 32'hFFFF_FFFE, 32'd3, 64'd0, wcnt, wcyc, wdat, idle);
        total++; if (wdat !== exp2) begin bad++; $display("FAIL chain_madd: got %h want %h", wdat, exp2); end
        use_reg = 1'b0;
    endtask

    task automatic test_flush_div();
        int wseen, wcnt, wcyc, idle;
        logic [63:0] wdat;
        wseen = 0;
        op = OP_DIV; src_a = 32'd1000; src_b = 32'd3; cur_drive = '0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (hilo_wen) wseen++;
            if (c == 10) flush = 1'b1;
            if (c == 11) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
                flush = 1'b0;
            end
        end
        total++; if (wseen !== 0) begin bad++; $display("FAIL flush_nowrite: got %0d want 0", wseen); end
        run_op(OP_MULTU, 32'd2, 32'd3, 64'd0, wcnt, wcyc, wdat, idle);
        total++; if (wdat !== 64'd6) begin bad++; $display("FAIL post_flush_data: got %h want 6", wdat); end
        total++; if (wcyc !== MUL_LAT) begin bad++; $display("FAIL post_flush_wcycle: got %0d want %0d", wcyc, MUL_LAT); end
    endtask

    task automatic test_ignore_start();
        int wcnt, idle;
        logic [63:0] wdat;
        wcnt = 0; idle = -1; wdat = '0;
        op = OP_MULT; src_a = 32'd7; src_b = 32'd9; cur_drive = '0; start = 1'b1;
        @(posedge clk); #1 op = OP_DIV;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (hilo_wen) begin wcnt++; wdat = hilo_wdata; end
            if (!busy && idle < 0) begin idle = c; start = 1'b0; end
        end
        start = 1'b0;
        total++; if (wcnt !== 1) begin bad++; $display("FAIL ignore_wcount: got %0d want 1", wcnt); end
        total++; if (wdat !== 64'd63) begin bad++; $display("FAIL ignore_data: got %h want 3f", wdat); end
        total++; if (idle !== MUL_LAT + 1) begin bad++; $display("FAIL ignore_idle: got %0d want %0d", idle, MUL_LAT + 1); end
    endtask

    task automatic test_flush_done();
        int wseen;
        wseen = 0;
        op = OP_MULT; src_a = 32'd3; src_b = 32'd4; cur_drive = '0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        if (hilo_wen) wseen++;
        @(negedge clk);
        flush = 1'b1;
        #1;
        total++; if (hilo_wen !== 1'b0) begin bad++; $display("FAIL flush_done_wen: got %b want 0", hilo_wen); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_done_busy: got %b want 1", busy); end
        @(negedge clk);
        flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_done_idle: got %b want 0", busy); end
        repeat (5) begin @(negedge clk); if (hilo_wen) wseen++; end
        total++; if (wseen !== 0) begin bad++; $display("FAIL flush_done_nowrite: got %0d want 0", wseen); end
    endtask

    task automatic test_random();
        int wcnt, wcyc, idle, lat;
        logic [63:0] wdat, exp, cur;
        logic [31:0] a, b;
        mdu_op_e o;
        for (int i = 0; i < 40; i++) begin
            o = mdu_op_e'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            cur = {$urandom, $urandom};
            exp = ref_result(o, a, b, cur);
            lat = ref_lat(o);
            run_op(o, a, b, cur, wcnt, wcyc, wdat, idle);
            total++; if (wcnt !== 1) begin bad++; $display("FAIL rnd%0d_wcount: got %0d want 1", i, wcnt); end
            total++; if (wcyc !== lat) begin bad++; $display("FAIL rnd%0d_wcycle: got %0d want %0d", i, wcyc, lat); end
            total++; if (wdat !== exp) begin bad++; $display("FAIL rnd%0d_data op=%0d a=%h b=%h: got %h want %h", i, o, a, b, wdat, exp); end
            total++; if (idle !== lat + 1) begin bad++; $display("FAIL rnd%0d_idle: got %0d want %0d", i, idle, lat + 1); end
        end
    endtask

    task automatic test_reset_mid();
        int wseen, bseen;
        wseen = 0; bseen = 0;
        op = OP_DIV; src_a = 32'd50; src_b = 32'd5; cur_drive = '0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        total++; if (hilo_wen !== 1'b0) begin bad++; $display("FAIL rstmid_wen: got %b want 0", hilo_wen); end
        total++; if (hilo_wdata !== 64'd0) begin bad++; $display("FAIL rstmid_wdata: got %h want 0", hilo_wdata); end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (hilo_wen) wseen++;
            if (busy) bseen++;
        end
        total++; if (wseen !== 0) begin bad++; $display("FAIL rstmid_nowrite: got %0d want 0", wseen); end
        total++; if (bseen !== 0) begin bad++; $display("FAIL rstmid_nobusy: got %0d want 0", bseen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_chain();
        test_flush_div();
        test_ignore_start();
        test_flush_done();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
